// File: rtl/rca_pipe.sv
// Pipelined ripple-carry adder/subtractor: WIDTH bits split into STAGES chunks, one chunk per stage.
// A single shared advance enable stalls the whole pipeline when the output is held.
module rca_pipe #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CW = WIDTH / STAGES;

    logic en;

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] carry_q, carry_d;
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  b_d   [STAGES];
    logic              ovf_q, ovf_d;

    // Per-stage inputs: stage 0 from the ports, stage k from the registers of stage k-1.
    logic [WIDTH-1:0]  st_a [STAGES];
    logic [WIDTH-1:0]  st_b [STAGES];
    logic [WIDTH-1:0]  st_s [STAGES];
    logic [STAGES-1:0] st_c;
    logic [STAGES-1:0] st_v;

    assign en        = ~valid_q[STAGES-1] | out_ready;
    assign in_ready  = en;
    assign out_valid = valid_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign cout      = carry_q[STAGES-1];
    assign ovf       = ovf_q;

    always_comb begin
        st_a[0] = inA;
        st_b[0] = sub ? ~inB : inB;
        st_c[0] = sub ? 1'b1 : cin;
        st_s[0] = '0;
        st_v[0] = in_valid;
        for (int unsigned k = 1; k < STAGES; k++) begin
            st_a[k] = a_q[k-1];
            st_b[k] = b_q[k-1];
            st_c[k] = carry_q[k-1];
            st_s[k] = sum_q[k-1];
            st_v[k] = valid_q[k-1];
        end
    end

    always_comb begin
        logic [WIDTH-1:0] s;
        logic             c;
        logic             cm;
        s       = '0;
        c       = 1'b0;
        cm      = 1'b0;
        ovf_d   = 1'b0;
        valid_d = '0;
        carry_d = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            s  = st_s[k];
            c  = st_c[k];
            cm = c;
            // Bit-serial ripple over this stage's chunk; cm ends as the carry into the chunk MSB.
            for (int unsigned i = 0; i < CW; i++) begin
                cm = c;
                s[k*CW+i] = st_a[k][k*CW+i] ^ st_b[k][k*CW+i] ^ c;
                c = (st_a[k][k*CW+i] & st_b[k][k*CW+i]) |
                    (c & (st_a[k][k*CW+i] ^ st_b[k][k*CW+i]));
            end
            sum_d[k]   = s;
            carry_d[k] = c;
            a_d[k]     = st_a[k];
            b_d[k]     = st_b[k];
            valid_d[k] = st_v[k];
            if (k == STAGES - 1) begin
                ovf_d = cm ^ c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                sum_q[k] <= '0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
            end
        end else if (en) begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            for (int unsigned k = 0; k < STAGES; k++) begin
                sum_q[k] <= sum_d[k];
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
            end
        end
    end

endmodule

// File: tb/tb_rca_pipe.sv
// Directed and scoreboarded checks of rca_pipe at 16/4, 8/1 and 32/8.
module tb_rca_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        iv0, ir0, ci0, sb0, ov0, or0, co0, of0;
    logic [15:0] a0, b0, s0;
    logic        iv1, ir1, ci1, sb1, ov1, or1, co1, of1;
    logic [7:0]  a1, b1, s1;
    logic        iv2, ir2, ci2, sb2, ov2, or2, co2, of2;
    logic [31:0] a2, b2, s2;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [33:0] r;
        int          cyc;
    } exp_t;

    rca_pipe #(.WIDTH(16), .STAGES(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .inA(a0), .inB(b0),
        .cin(ci0), .sub(sb0), .out_valid(ov0), .out_ready(or0), .sum(s0), .cout(co0), .ovf(of0)
    );

    rca_pipe #(.WIDTH(8), .STAGES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .inA(a1), .inB(b1),
        .cin(ci1), .sub(sb1), .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1), .ovf(of1)
    );

    rca_pipe #(.WIDTH(32), .STAGES(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .inA(a2), .inB(b2),
        .cin(ci2), .sub(sb2), .out_valid(ov2), .out_ready(or2), .sum(s2), .cout(co2), .ovf(of2)
    );

    // Returns {ovf, cout, sum zero-extended to 32 bits} for a w-bit add/sub.
    function automatic logic [33:0] model(int unsigned w, logic [31:0] a, logic [31:0] b,
                                          logic ci, logic s);
        logic [63:0] m, bb, full, low;
        logic        c;
        m    = (64'd1 << w) - 64'd1;
        bb   = s ? (~{32'd0, b}) & m : {32'd0, b} & m;
        c    = s ? 1'b1 : ci;
        full = ({32'd0, a} & m) + bb + {63'd0, c};
        low  = ({32'd0, a} & (m >> 1)) + (bb & (m >> 1)) + {63'd0, c};
        return {low[w-1] ^ full[w], full[w], full[31:0] & m[31:0]};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        #2;
        n_checks++;
        if ({ov0, s0, co0, of0} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b sum=%h cout=%b ovf=%b, expected all 0",
                     ov0, s0, co0, of0);
        end
        n_checks++;
        if ({ov1, ov2} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_sweep_valid: got %b%b, expected 00", ov1, ov2);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ir0 !== 1'b1 || ov0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b, expected 1 0", ir0, ov0);
        end
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb,
                        input logic [15:0] es, input logic ec, input logic eo, input string name);
        @(posedge clk);
        #1;
        iv0 = 1'b1; a0 = a; b0 = b; ci0 = ci; sb0 = sb; or0 = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ir0 !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_in_ready: got %b, expected 1", name, ir0);
        end
        @(posedge clk);
        #1;
        iv0 = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (i < 4) begin
                if (ov0 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s_early: out_valid=%b at cycle %0d, expected 0", name, ov0, i);
                end
            end else if ({ov0, s0, co0, of0} !== {1'b1, es, ec, eo}) begin
                n_fail++;
                $display("FAIL %s: got valid=%b sum=%h cout=%b ovf=%b, expected 1 %h %b %b",
                         name, ov0, s0, co0, of0, es, ec, eo);
            end
        end
    endtask

    task automatic test_add_overflow();
        op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "wrap");
        op16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "signed_ovf");
        op16(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");
    endtask

    task automatic test_carry_chain();
        op16(16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, "chunk_carry");
        op16(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, "full_ripple");
    endtask

    task automatic test_back_to_back();
        exp_t        q[$];
        exp_t        e;
        int          sent = 0;
        int          got  = 0;
        int          cyc  = 0;
        logic        hold = 1'b0;
        logic        xfer;
        logic [15:0] hold_sum = '0;
        @(posedge clk);
        #1;
        iv0 = 1'b1; a0 = 16'($urandom); b0 = 16'($urandom);
        ci0 = 1'($urandom); sb0 = 1'($urandom); or0 = 1'b1;
        while ((sent < 20 || q.size() > 0) && cyc < 400) begin
            @(negedge clk);
            cyc++;
            n_checks++;
            if (ir0 !== !(ov0 && !or0)) begin
                n_fail++;
                $display("FAIL b2b_in_ready: got %b with out_valid=%b out_ready=%b", ir0, ov0, or0);
            end
            if (hold) begin
                n_checks++;
                if (ov0 !== 1'b1 || s0 !== hold_sum) begin
                    n_fail++;
                    $display("FAIL b2b_stall_hold: got valid=%b sum=%h, expected 1 %h",
                             ov0, s0, hold_sum);
                end
            end
            hold     = ov0 && !or0;
            hold_sum = s0;
            if (ov0 && or0) begin
                n_checks++;
                got++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_extra: unexpected result sum=%h", s0);
                end else begin
                    e = q.pop_front();
                    if ({of0, co0, s0} !== {e.r[33], e.r[32], e.r[15:0]}) begin
                        n_fail++;
                        $display("FAIL b2b_result: got sum=%h cout=%b ovf=%b, expected %h %b %b",
                                 s0, co0, of0, e.r[15:0], e.r[32], e.r[33]);
                    end
                end
            end
            xfer = iv0 && ir0;
            if (xfer) begin
                e.r   = model(16, {16'd0, a0}, {16'd0, b0}, ci0, sb0);
                e.cyc = cyc;
                q.push_back(e);
                sent++;
            end
            @(posedge clk);
            #1;
            if (xfer) begin
                if (sent < 20) begin
                    a0 = 16'($urandom); b0 = 16'($urandom);
                    ci0 = 1'($urandom); sb0 = 1'($urandom);
                end else begin
                    iv0 = 1'b0;
                end
            end
            or0 = (cyc >= 8 && cyc < 14) ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
        or0 = 1'b1;
        n_checks++;
        if (cyc >= 400 || got != 20) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d results in %0d cycles, expected 20", got, cyc);
        end
    endtask

    task automatic test_reset_mid();
        or0 = 1'b1;
        @(posedge clk);
        #1;
        iv0 = 1'b1; a0 = 16'h1234; b0 = 16'h1111; ci0 = 1'b0; sb0 = 1'b0;
        @(posedge clk);
        #1;
        a0 = 16'h4000; b0 = 16'h0321;
        @(posedge clk);
        #1;
        a0 = 16'h0F0F; b0 = 16'h0101;
        @(posedge clk);
        #1;
        iv0 = 1'b0;
        @(posedge clk);
        #2;
        n_checks++;
        if (ov0 !== 1'b1 || s0 !== 16'h2345) begin
            n_fail++;
            $display("FAIL rst_mid_pre: got valid=%b sum=%h, expected 1 2345", ov0, s0);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ov0, s0, co0, of0} !== 19'd0) begin
            n_fail++;
            $display("FAIL rst_mid_clear: got valid=%b sum=%h cout=%b ovf=%b, expected all 0",
                     ov0, s0, co0, of0);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_checks++;
            if (ov0 !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid_stale: out_valid=%b sum=%h at cycle %0d, expected 0",
                         ov0, s0, i);
            end
        end
    endtask

    task automatic test_sweep();
        exp_t q1[$];
        exp_t q2[$];
        exp_t e;
        int   sent1 = 0;
        int   sent2 = 0;
        int   cyc   = 0;
        logic x1, x2;
        @(posedge clk);
        #1;
        or1 = 1'b1; or2 = 1'b1; iv1 = 1'b1; iv2 = 1'b1;
        a1 = 8'($urandom); b1 = 8'($urandom); ci1 = 1'($urandom); sb1 = 1'($urandom);
        a2 = $urandom; b2 = $urandom; ci2 = 1'($urandom); sb2 = 1'($urandom);
        while ((sent1 < 1000 || sent2 < 1000 || q1.size() > 0 || q2.size() > 0) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (ov1) begin
                n_checks++;
                if (q1.size() == 0) begin
                    n_fail++;
                    $display("FAIL sweep8_extra: unexpected result sum=%h", s1);
                end else begin
                    e = q1.pop_front();
                    if ({of1, co1, s1} !== {e.r[33], e.r[32], e.r[7:0]} || cyc - e.cyc != 1) begin
                        n_fail++;
                        $display("FAIL sweep8: got sum=%h cout=%b ovf=%b lat=%0d, expected %h %b %b lat=1",
                                 s1, co1, of1, cyc - e.cyc, e.r[7:0], e.r[32], e.r[33]);
                    end
                end
            end
            if (ov2) begin
                n_checks++;
                if (q2.size() == 0) begin
                    n_fail++;
                    $display("FAIL sweep32_extra: unexpected result sum=%h", s2);
                end else begin
                    e = q2.pop_front();
                    if ({of2, co2, s2} !== e.r || cyc - e.cyc != 8) begin
                        n_fail++;
                        $display("FAIL sweep32: got sum=%h cout=%b ovf=%b lat=%0d, expected %h %b %b lat=8",
                                 s2, co2, of2, cyc - e.cyc, e.r[31:0], e.r[32], e.r[33]);
                    end
                end
            end
            x1 = iv1 && ir1;
            x2 = iv2 && ir2;
            if (x1) begin
                e.r = model(8, {24'd0, a1}, {24'd0, b1}, ci1, sb1);
                e.cyc = cyc;
                q1.push_back(e);
                sent1++;
            end
            if (x2) begin
                e.r = model(32, a2, b2, ci2, sb2);
                e.cyc = cyc;
                q2.push_back(e);
                sent2++;
            end
            @(posedge clk);
            #1;
            if (x1) begin
                if (sent1 < 1000) begin
                    a1 = 8'($urandom); b1 = 8'($urandom); ci1 = 1'($urandom); sb1 = 1'($urandom);
                end else begin
                    iv1 = 1'b0;
                end
            end
            if (x2) begin
                if (sent2 < 1000) begin
                    a2 = $urandom; b2 = $urandom; ci2 = 1'($urandom); sb2 = 1'($urandom);
                end else begin
                    iv2 = 1'b0;
                end
            end
        end
        n_checks++;
        if (cyc >= 3000 || sent1 != 1000 || sent2 != 1000) begin
            n_fail++;
            $display("FAIL sweep_count: sent %0d/%0d in %0d cycles, expected 1000/1000",
                     sent1, sent2, cyc);
        end
    endtask

    initial begin
        iv0 = 1'b0; a0 = '0; b0 = '0; ci0 = 1'b0; sb0 = 1'b0; or0 = 1'b1;
        iv1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0; sb1 = 1'b0; or1 = 1'b1;
        iv2 = 1'b0; a2 = '0; b2 = '0; ci2 = 1'b0; sb2 = 1'b0; or2 = 1'b1;
        test_reset();
        test_add_overflow();
        test_carry_chain();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rca_pipe.md
Name: rca_pipe

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor. It is the successor to the team's fixed 8-bit combinational ripple-carry adder.
- An operand of WIDTH bits is split into STAGES equal chunks. Each pipeline stage ripples one chunk and registers its carry into the next stage.
- Adds add/subtract mode, a signed-overflow flag and a valid/ready handshake on both sides. It feeds the ALU result mux and sustains one operation per clock.

Parameters:
WIDTH, 16, operand and sum width in bits; must be a multiple of STAGES.
STAGES, 4, number of pipeline stages; chunk width CW = WIDTH/STAGES; legal range 1..WIDTH.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operands on inA/inB/cin/sub are valid.
in_ready  output  1  block accepts operands this cycle.
inA  input  WIDTH  operand A.
inB  input  WIDTH  operand B.
cin  input  1  carry-in; used only when sub=0.
sub  input  1  0: A+B+cin; 1: A+~B+1 (A-B), cin ignored.
out_valid  output  1  sum/cout/ovf valid.
out_ready  input  1  downstream accepts result.
sum  output  WIDTH  result, modulo 2^WIDTH.
cout  output  1  carry out of bit WIDTH-1. For subtraction, 1 means no borrow.
ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Transfers: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
- Global advance enable: en = ~out_valid | out_ready; in_ready = en (combinational, no dependency on in_valid).
- Stall: when en=0, every pipeline register holds its value and sum/cout/ovf/out_valid stay stable.
- Bubbles: not squeezed out; a bubble advances only when en=1.
- Stage 1:
  - registers chunk 0 of inA + (sub ? ~inB : inB) + (sub ? 1 : cin) with its carry;
  - registers the unprocessed upper chunks of A and effective B (skew registers);
  - registers valid = in_valid.
- Stage k (2..STAGES):
  - adds chunk k-1 using the carry registered by stage k-1;
  - passes lower sum bits forward unchanged and remaining operand chunks forward;
  - carries the valid bit along.
- Final stage drives sum, cout, ovf and out_valid directly from registers. The ovf term uses the carry into the MSB, computed inside the last chunk's ripple.
- Latency: a result appears on out_valid exactly STAGES cycles after its input transfer, given no stall. Throughput is 1 per cycle.
- Ordering: results leave in acceptance order; no loss or duplication under any out_ready pattern.
- STAGES=1: a single registered adder, latency 1.
- Reset (async assert, synchronous deassert by the system):
  - all valid bits = 0, out_valid = 0, sum = 0, cout = 0, ovf = 0;
  - data registers cleared to 0;
  - in_ready = 1 on the first cycle after reset release.
- Reset mid-operation: all in-flight operations are discarded and no partial result is emitted.
- Data registers may load when their valid bit is 0. Outputs are don't-care while out_valid=0, except after reset, where they are 0.
- Wrap-around: sum is truncated to WIDTH bits; the carry is reported only on cout.
- No internal state machine beyond the valid shift chain; the enable is shared by all stages.

Test Plan:
- WIDTH=16, STAGES=4: inA=0xFFFF, inB=0x0001, cin=0, sub=0, out_ready=1 -> 4 cycles later sum=0x0000, cout=1, ovf=0.
- inA=0x7FFF, inB=0x0001, sub=0 -> sum=0x8000, cout=0, ovf=1. Then inA=0x0005, inB=0x0007, sub=1, cin=1 -> sum=0xFFFE, cout=0, ovf=0.
- Back-to-back: 20 random operations on consecutive cycles with out_ready toggling pseudo-randomly, plus one 6-cycle stall:
  - outputs match the reference model in order, with no drop or duplicate;
  - sum is stable while out_valid & ~out_ready;
  - in_ready = 0 exactly when out_valid & ~out_ready.
- Carry chain across chunks: inA=0x0FFF, inB=0x0001, cin=0 -> sum=0x1000. Then inA=0xFFFF, inB=0x0000, cin=1 -> sum=0x0000, cout=1, confirming carry ripples through all 4 stages.
- Reset mid-operation: accept 3 operations, assert rst_n=0 for 1 cycle (asynchronously, mid-cycle) -> out_valid=0 and sum=0 immediately; no stale result ever appears after release.
- Parameter sweep: WIDTH=8/STAGES=1 (latency 1) and WIDTH=32/STAGES=8 (latency 8). Run 1000 random add/sub operations each -> all match the model, including cout and ovf.
